// File: rtl/digit_scan_pkg.sv
// Shared types and constants for the four-digit seven-segment scan controller.
// Contents: scan_state_t, display word payload, blanking constants and the
// active-low {g,f,e,d,c,b,a} hex-to-segment table.
// Optional feature macro used by the users of this package: DIGIT_DP_EN.
package digit_scan_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned AN_W    = 4;
  localparam int unsigned NUM_DIG = 4;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  // Display payload: dig -> digits 3/2, an -> digits 1/0 (low nibble = lower digit).
  typedef struct packed {
    logic [BYTE_W-1:0] dig;
    logic [BYTE_W-1:0] an;
  } disp_word_t;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [AN_W-1:0]  AN_OFF    = 4'hF;

  // Entry n is the segment pattern for hex digit n (listed F down to 0).
  localparam logic [15:0][SEG_W-1:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/digit_scan_ctrl_if.sv
// CPU write path and display-side signals of digit_scan_ctrl.
//   an_in/dig_in/wr_en  : display bytes and capture strobe (master -> slave)
//   pending             : shadow holds uncommitted data (slave -> master)
//   frame_start         : one-cycle pulse at digit 0 slot start
//   an_sel/seg          : active-low anode select and segment bus
// With DIGIT_DP_EN defined: dp_mask in (per-digit decimal point), dp out (active-low).
interface digit_scan_ctrl_if;
  import digit_scan_pkg::*;

  logic [BYTE_W-1:0] an_in;
  logic [BYTE_W-1:0] dig_in;
  logic              wr_en;
  logic              pending;
  logic              frame_start;
  logic [AN_W-1:0]   an_sel;
  logic [SEG_W-1:0]  seg;
`ifdef DIGIT_DP_EN
  logic [NUM_DIG-1:0] dp_mask;
  logic               dp;

  modport master (output an_in, dig_in, wr_en, dp_mask,
                  input  pending, frame_start, an_sel, seg, dp);
  modport slave  (input  an_in, dig_in, wr_en, dp_mask,
                  output pending, frame_start, an_sel, seg, dp);
`else
  modport master (output an_in, dig_in, wr_en,
                  input  pending, frame_start, an_sel, seg);
  modport slave  (input  an_in, dig_in, wr_en,
                  output pending, frame_start, an_sel, seg);
`endif

endinterface

// File: rtl/hex7seg_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
//   nibble : 4-bit hex value
//   seg_c  : {g,f,e,d,c,b,a}, active-low
module hex7seg_decode
  import digit_scan_pkg::*;
(
  input  logic [NIB_W-1:0] nibble,
  output logic [SEG_W-1:0] seg_c
);

  assign seg_c = HEX_SEG[nibble];

endmodule

// File: rtl/digit_scan_ctrl.sv
// Four-digit common-anode seven-segment scan controller with shadowed,
// frame-atomic display updates and inter-digit blanking.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : digit_scan_ctrl_if.slave (write path in, display/status out)
// Parameters: SCAN_DIV cycles per digit slot, BLANK_CYC blank cycles per slot.
// Optional: DIGIT_DP_EN adds dp_mask capture and the active-low dp output.
module digit_scan_ctrl
  import digit_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic             clk,
  input  logic             reset,
  digit_scan_ctrl_if.slave bus
);

  localparam int unsigned      CNT_W       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST  = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam scan_state_t      SLOT_STATE  = (BLANK_CYC == 0) ? SHOW : BLANK;

  scan_state_t                   state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  disp_word_t                    shadow_q, shadow_d, active_q, active_d, wr_word_c;
  logic                          pending_q, pending_d;
  logic                          frame_start_q, frame_start_d;
  logic [AN_W-1:0]               an_sel_q, an_sel_d;
  logic [SEG_W-1:0]              seg_q, seg_d;
  logic [NUM_DIG-1:0][NIB_W-1:0] nibbles_c;
  logic [SEG_W-1:0]              dec_seg_c;
  logic                          slot_end_c, wrap_c;
`ifdef DIGIT_DP_EN
  logic [NUM_DIG-1:0]            shadow_dp_q, shadow_dp_d, active_dp_q, active_dp_d;
  logic                          dp_q, dp_d;
`endif

  assign wr_word_c  = '{dig: bus.dig_in, an: bus.an_in};
  assign nibbles_c  = active_q;
  assign slot_end_c = (cnt_q == CNT_LAST);
  assign wrap_c     = slot_end_c && (idx_q == IDX_W'(NUM_DIG - 1));

  hex7seg_decode u_dec (
    .nibble (nibbles_c[idx_q]),
    .seg_c  (dec_seg_c)
  );

  // Slot sequencing, shadow/commit handling and next output values.
  // Outputs are derived from the current scan position so an_sel and seg
  // always move together on the same edge.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + CNT_W'(1);
    idx_d         = idx_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    pending_d     = pending_q;
    frame_start_d = (cnt_q == '0) && (idx_q == '0);
    an_sel_d      = AN_OFF;
    seg_d         = SEG_BLANK;
`ifdef DIGIT_DP_EN
    shadow_dp_d   = shadow_dp_q;
    active_dp_d   = active_dp_q;
    dp_d          = 1'b1;
`endif

    if (slot_end_c) begin
      cnt_d   = '0;
      idx_d   = idx_q + IDX_W'(1);
      state_d = SLOT_STATE;
    end else if (state_q == BLANK && cnt_q == BLANK_LAST) begin
      state_d = SHOW;
    end

    if (bus.wr_en) begin
      shadow_d = wr_word_c;
`ifdef DIGIT_DP_EN
      shadow_dp_d = bus.dp_mask;
`endif
    end

    // A write landing on the wrap cycle bypasses the shadow and commits directly.
    if (wrap_c && bus.wr_en) begin
      active_d  = wr_word_c;
      pending_d = 1'b0;
`ifdef DIGIT_DP_EN
      active_dp_d = bus.dp_mask;
`endif
    end else if (wrap_c && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
`ifdef DIGIT_DP_EN
      active_dp_d = shadow_dp_q;
`endif
    end else if (bus.wr_en) begin
      pending_d = 1'b1;
    end

    if (state_q == SHOW) begin
      an_sel_d = ~(AN_W'(1) << idx_q);
      seg_d    = dec_seg_c;
`ifdef DIGIT_DP_EN
      dp_d     = ~active_dp_q[idx_q];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SLOT_STATE;
      cnt_q         <= '0;
      idx_q         <= '0;
      shadow_q      <= '0;
      active_q      <= '0;
      pending_q     <= 1'b0;
      frame_start_q <= 1'b0;
      an_sel_q      <= AN_OFF;
      seg_q         <= SEG_BLANK;
`ifdef DIGIT_DP_EN
      shadow_dp_q   <= '0;
      active_dp_q   <= '0;
      dp_q          <= 1'b1;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      pending_q     <= pending_d;
      frame_start_q <= frame_start_d;
      an_sel_q      <= an_sel_d;
      seg_q         <= seg_d;
`ifdef DIGIT_DP_EN
      shadow_dp_q   <= shadow_dp_d;
      active_dp_q   <= active_dp_d;
      dp_q          <= dp_d;
`endif
    end
  end

  assign bus.pending     = pending_q;
  assign bus.frame_start = frame_start_q;
  assign bus.an_sel      = an_sel_q;
  assign bus.seg         = seg_q;
`ifdef DIGIT_DP_EN
  assign bus.dp          = dp_q;
`endif

endmodule
